// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states and the
// buffered MDU result entry.
package wb_arb_pkg;

  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEAL = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd_addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO of MDU result entries; exposes every slot plus a
// per-slot valid vector so the top can build the pending-destination mask.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  wb_entry_t                 i_entry,
  output wb_entry_t                 o_head,
  output wb_entry_t [DEPTH-1:0]     o_entries,
  output logic [DEPTH-1:0]          o_valid,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
  logic [PW:0]   count_q, count_d;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (i_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    o_valid = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rd_ptr_q;
      o_valid[i] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) mem_q <= mem_d;

  assign o_head    = mem_q[rd_ptr_q];
  assign o_entries = mem_q;
  assign o_count   = count_q;
  assign o_full    = (count_q == (PW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, MDU bypass/buffer/steal.
// Optional WB_ARB_STATS_EN enables the steal and MDU-write statistics counters.
//
// state | meaning
// IDLE  | result FIFO empty
// WAIT  | buffered MDU results waiting for a free write slot
// STEAL | one-cycle pipeline stall, FIFO head owns the port
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int REG_ADDR_W   = WB_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pipe_we,
  input  logic [REG_ADDR_W-1:0]    i_pipe_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_pipe_result,
  input  logic                     i_mdu_valid,
  input  logic [REG_ADDR_W-1:0]    i_mdu_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_mdu_result,
  output logic                     o_mdu_ready,
  output logic                     o_stall_pipe,
  output logic                     o_rf_we,
  output logic [REG_ADDR_W-1:0]    o_rf_rd_addr,
  output logic [DATA_WIDTH-1:0]    o_rf_data,
  output logic [2**REG_ADDR_W-1:0] o_pending_mask,
  output logic [15:0]              o_steal_cnt,
  output logic [15:0]              o_mdu_wr_cnt
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_e state_q, state_d;
  logic [SW-1:0] starve_left_q, starve_left_d;
  logic steal, pipe_act, free_slot, deq, enq, bypass, mdu_ready;
  logic [CNT_W-1:0] count_after;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [2**REG_ADDR_W-1:0] mask;

  wb_entry_t head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [CNT_W-1:0] fifo_count;
  logic fifo_full, fifo_empty;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (enq),
    .i_pop     (deq),
    .i_entry   ('{rd_addr: i_mdu_rd_addr, data: i_mdu_result}),
    .o_head    (head),
    .o_entries (entries),
    .o_valid   (ent_valid),
    .o_count   (fifo_count),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_comb begin
    steal     = (state_q == STEAL);
    pipe_act  = i_pipe_we && (i_pipe_rd_addr != '0) && !steal;
    free_slot = !steal && !pipe_act;
    deq       = !fifo_empty && (steal || free_slot);
    mdu_ready = !fifo_full;
    bypass    = free_slot && fifo_empty && i_mdu_valid && (i_mdu_rd_addr != '0);
    enq       = i_mdu_valid && mdu_ready && (i_mdu_rd_addr != '0) && !bypass;
    count_after = fifo_count + CNT_W'(enq) - CNT_W'(deq);

    // Down-counter of occupied-slot cycles left before the head may steal.
    if (deq || count_after == '0)                   starve_left_d = SW'(STARVE_LIMIT);
    else if (pipe_act && starve_left_q != '0)       starve_left_d = starve_left_q - 1'b1;
    else                                            starve_left_d = starve_left_q;

    if (count_after == '0)                             state_d = IDLE;
    else if (pipe_act && starve_left_d == '0)          state_d = STEAL;
    else                                               state_d = WAIT;

    rf_addr = i_pipe_rd_addr;
    rf_data = i_pipe_result;
    if (deq) begin
      rf_addr = head.rd_addr;
      rf_data = head.data;
    end else if (bypass) begin
      rf_addr = i_mdu_rd_addr;
      rf_data = i_mdu_result;
    end

    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_valid[i]) mask[entries[i].rd_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      starve_left_q <= SW'(STARVE_LIMIT);
    end else begin
      state_q       <= state_d;
      starve_left_q <= starve_left_d;
    end
  end

  assign o_rf_we        = (pipe_act || deq || bypass) && !i_rst;
  assign o_rf_rd_addr   = rf_addr;
  assign o_rf_data      = rf_data;
  assign o_stall_pipe   = steal && !i_rst;
  assign o_mdu_ready    = mdu_ready && !i_rst;
  assign o_pending_mask = i_rst ? '0 : mask;

`ifdef WB_ARB_STATS_EN
  logic [15:0] steal_cnt_q, steal_cnt_d, mdu_wr_cnt_q, mdu_wr_cnt_d;

  always_comb begin
    steal_cnt_d  = steal_cnt_q + 16'(steal);
    mdu_wr_cnt_d = mdu_wr_cnt_q + 16'(deq || bypass);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      steal_cnt_q  <= '0;
      mdu_wr_cnt_q <= '0;
    end else begin
      steal_cnt_q  <= steal_cnt_d;
      mdu_wr_cnt_q <= mdu_wr_cnt_d;
    end
  end

  assign o_steal_cnt  = steal_cnt_q;
  assign o_mdu_wr_cnt = mdu_wr_cnt_q;
`else
  assign o_steal_cnt  = '0;
  assign o_mdu_wr_cnt = '0;
`endif

endmodule
